// File: rtl/dmem_responder.sv
// Load/store responder over valid/ready in front of a word-addressed synchronous RAM.
// Optional macro DMEM_BOUNDS_CHECK_EN flags and suppresses accesses above the RAM range.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic [ADDR_WIDTH-1:0]   idx_p0;
  logic                    accept_p0;
  logic                    oob_p0;
  logic                    err_p1;
  logic                    unused_addr;

  assign req_ready = (state == IDLE) & ~rst;
  assign accept_p0 = req_valid & req_ready;
  assign idx_p0    = req_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_p0 = |req_addr[31:ADDR_WIDTH+2];
`else
  assign oob_p0 = 1'b0;
`endif

  // Byte offset is never used; upper bits only feed the optional bounds check.
  assign unused_addr = ^{req_addr[1:0], req_addr[31:ADDR_WIDTH+2]};

  // Stage p0 -> p1: RAM write on acceptance, registered read for loads
  always_ff @(posedge clk) begin
    if (accept_p0 && req_write && !oob_p0) begin
      mem[idx_p0] <= req_wdata;
    end
    if (accept_p0 && !req_write) begin
      rd_data_p1 <= mem[idx_p0];
    end
  end

  // Stage p1 -> response: FSM drives registered response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_p0) begin
            err_p1 <= oob_p0;
            if (req_write) begin
              rsp_write <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= oob_p0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_write <= 1'b0;
              state     <= READ;
            end
          end
        end
        READ: begin
          rsp_rdata <= err_p1 ? '0 : rd_data_p1;
          rsp_write <= 1'b0;
          rsp_err   <= err_p1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized load/store traffic
// checked against a sparse word-memory model.
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] model [int];

  dmem_responder #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; stall = cycles with rsp_ready low in RESP.
  task automatic do_op(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall);
    int          idx;
    logic        oob;
    logic        known;
    logic [31:0] exp_d;
    idx = int'(addr[ADDR_W+1:2]);
    oob = BCHK && (addr[31:ADDR_W+2] != '0);
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (stall == 0);
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk("busy_req_ready", {31'b0, req_ready}, 32'd0);
    if (!wr) begin
      chk("load_lat_no_vld", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    if (wr) begin
      exp_d = '0;
      known = 1'b1;
      if (!oob) model[idx] = wd;
    end else if (oob) begin
      exp_d = '0;
      known = 1'b1;
    end else if (model.exists(idx)) begin
      exp_d = model[idx];
      known = 1'b1;
    end else begin
      exp_d = '0;
      known = 1'b0;
    end
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_write", {31'b0, rsp_write}, {31'b0, wr});
      if (known) chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, oob});
      chk("resp_req_ready", {31'b0, req_ready}, 32'd0);
      if (s == stall) begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
      end else begin
        // a competing store that must be ignored while busy
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = ~wd;
      end
      tick();
    end
    chk("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("done_req_ready", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    do_op(1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_op(1'b0, 32'h10, 32'h0, 0);
    do_op(1'b0, 32'h10, 32'h0, 5);
    do_op(1'b1, 32'h14, 32'h0BADF00D, 3);
    do_op(1'b0, 32'h13, 32'h0, 0);

    do_op(1'b1, 32'h0000, 32'h0000AAAA, 0);
    do_op(1'b1, 32'h1000, BCHK ? 32'h00005555 : 32'h00001234, 0);
    do_op(1'b0, 32'h0000, 32'h0, 0);
    do_op(1'b0, 32'h1000, 32'h0, 1);

    // Reset while the load sits in READ: response is dropped
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("midload_no_vld", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b1;
    tick();
    chk("midload_rst_vld", {31'b0, rsp_valid}, 32'd0);
    chk("midload_rst_rdy", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_abort_vld", {31'b0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    do_op(1'b0, 32'h10, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom_range(1, 255) << 12);
      do_op(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
